relu_share_sched: RTL and testbench

- Round-robin scheduler sharing one pipelined 16-bit ReLU unit among N_REQ requesters.
- Arbitrates valid/ready requests and drives the shared unit's data input. Tracks in-flight operands with a tag shift register matched to the unit latency.
- Collects results in a credit-protected result FIFO and returns them on one tagged valid/ready port.
- Sits between the vector lanes and the activation stage; a flush handshake drains the block before mode changes.

---
 rtl/relu_sched_pkg.sv | 27 ++
 rtl/relu_res_fifo.sv | 50 +++++
 rtl/relu_share_sched.sv | 158 +++++++++++++++
 tb/tb_relu_share_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/relu_sched_pkg.sv
// Shared types and defaults for the round-robin ReLU scheduler.
package relu_sched_pkg;

    localparam int N_REQ_DEF      = 4;
    localparam int DATA_W_DEF     = 16;
    localparam int UNIT_LAT_DEF   = 1;
    localparam int FIFO_DEPTH_DEF = 4;
    // Tag id field is sized for the largest requester count we expect to build.
    localparam int TAG_ID_W       = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
        logic                sign;
    } tag_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/relu_res_fifo.sv
// Synchronous result FIFO with occupancy count; DEPTH must be a power of two.
module relu_res_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is cleared too so the head reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == CW'(DEPTH)));

endmodule

// File: rtl/relu_share_sched.sv
// Round-robin scheduler sharing one pipelined ReLU unit among N_REQ requesters.
// Define ACT_STATS_EN to add saturating issue/clamp statistics counters.
module relu_share_sched
    import relu_sched_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int UNIT_LAT   = UNIT_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       unit_data_o,
    input  logic [DATA_W-1:0]       unit_data_i,
    output logic                    res_valid,
    output logic [DATA_W-1:0]       res_data,
    output logic [ID_W-1:0]         res_id,
    input  logic                    res_ready,
    input  logic                    flush_req,
    output logic                    flush_done,
    output logic                    busy
`ifdef ACT_STATS_EN
    ,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_clamped
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                         state, state_nxt;
    logic [N_REQ-1:0][DATA_W-1:0]   req_op;
    logic [ID_W-1:0]                rr_ptr, gnt_idx;
    logic [ID_W:0]                  scan_idx;
    logic                           gnt_found, grant_en, grant, credit_ok;
    tag_t                           tag_pipe [UNIT_LAT];
    tag_t                           tag_in, tag_out;
    logic [CW-1:0]                  fifo_count, inflight;
    logic                           fifo_empty, push;
    logic [ID_W+DATA_W-1:0]         head;
    logic                           unused_tag;

    assign req_op = req_data;

    // Rotating priority: first valid requester at or after rr_ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N_REQ)) scan_idx = scan_idx - (ID_W+1)'(N_REQ);
            if (!gnt_found && req_valid[scan_idx[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int s = 0; s < UNIT_LAT; s++) inflight = inflight + CW'(tag_pipe[s].valid);
    end

    // Credits cover both operands inside the unit and results parked in the FIFO.
    assign credit_ok = (fifo_count + inflight) < CW'(FIFO_DEPTH);
    assign busy      = (inflight != '0) || !fifo_empty;
    assign grant     = rst_n && grant_en && gnt_found;
    assign req_ready = grant ? (N_REQ'(1) << gnt_idx) : '0;

    assign tag_in.valid = grant;
    assign tag_in.id    = TAG_ID_W'(gnt_idx);
    assign tag_in.sign  = req_op[gnt_idx][DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            unit_data_o <= '0;
            for (int s = 0; s < UNIT_LAT; s++) tag_pipe[s] <= '0;
        end else begin
            if (grant) begin
                unit_data_o <= req_op[gnt_idx];
                rr_ptr      <= (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
            end
            tag_pipe[0] <= tag_in;
            for (int s = 1; s < UNIT_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
        end
    end

    // The last tag stage lines up with the unit result for that operand.
    assign tag_out    = tag_pipe[UNIT_LAT-1];
    assign push       = tag_out.valid;
    assign unused_tag = ^{tag_out.id[TAG_ID_W-1:ID_W], tag_out.sign};

    relu_res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ID_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({tag_out.id[ID_W-1:0], unit_data_i}),
        .pop       (res_valid && res_ready),
        .pop_data  (head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign res_valid          = !fifo_empty;
    assign {res_id, res_data} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flush_req) state_nxt = DRAIN;
                     else if (|req_valid) state_nxt = RUN;
            RUN:     if (flush_req) state_nxt = DRAIN;
                     else if (!(|req_valid) && !busy) state_nxt = IDLE;
            DRAIN:   if (!busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_en   = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE, RUN: grant_en   = !flush_req && credit_ok;
            DRAIN:     flush_done = !busy;
            default:   ;
        endcase
    end

`ifdef ACT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_clamped <= '0;
        end else if (flush_done) begin
            stat_issued  <= '0;
            stat_clamped <= '0;
        end else begin
            if (grant) stat_issued <= sat_inc(stat_issued);
            if (push && tag_out.sign && unit_data_i == '0) stat_clamped <= sat_inc(stat_clamped);
        end
    end
`endif

endmodule

// File: tb/tb_relu_share_sched.sv
// Randomized/directed bench for relu_share_sched against a queue-based reference model.
module tb_relu_share_sched;

    localparam int N     = 4;
    localparam int DW    = 16;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int IDW   = 2;

    logic            clk, rst_n;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0]   unit_data_o, unit_data_i, res_data;
    logic [IDW-1:0]  res_id;
    logic            res_valid, res_ready, flush_req, flush_done, busy;
`ifdef ACT_STATS_EN
    logic [31:0]     stat_issued, stat_clamped;
`endif

    relu_share_sched #(.N_REQ(N), .DATA_W(DW), .UNIT_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .unit_data_o (unit_data_o),
        .unit_data_i (unit_data_i),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_id      (res_id),
        .res_ready   (res_ready),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .busy        (busy)
`ifdef ACT_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_clamped(stat_clamped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

    // Shared unit with a one-cycle latency measured from the grant: combinational on the registered operand.
    assign unit_data_i = relu(unit_data_o);

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            gcyc;
    } exp_t;

    exp_t q[$];
    int   ptr, cyc, n_tests, n_fail;
    bit   draining, saw_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: called at a falling edge with inputs set; checks, advances the model, waits for next falling edge.
    task automatic cycle();
        logic [N-1:0] exp_rdy;
        logic         exp_rv, exp_fd;
        int           g;
        exp_t         e;
        #1;
        exp_rdy = '0;
        g = -1;
        if (!flush_req && q.size() < DEPTH)
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = (q.size() > 0) && (cyc - q[0].gcyc >= LAT + 1);
        exp_fd = draining && (q.size() == 0);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("flush_done", 32'(flush_done), 32'(exp_fd));
        if (exp_rv) begin
            chk("res_data", 32'(res_data), 32'(q[0].data));
            chk("res_id", 32'(res_id), 32'(q[0].id));
        end
        saw_done = flush_done;
        if (exp_rv && res_ready) void'(q.pop_front());
        if (g >= 0) begin
            e.id   = g;
            e.data = relu(req_data[g*DW +: DW]);
            e.gcyc = cyc;
            q.push_back(e);
            ptr = (g + 1) % N;
        end
        if (exp_fd) draining = 1'b0;
        else if (flush_req) draining = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain_wait(input string tag);
        saw_done = 1'b0;
        for (int i = 0; i < 40 && !saw_done; i++) cycle();
        chk(tag, 32'(saw_done), 32'd1);
        flush_req = 1'b0;
        cycle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_unit_data_o"}, 32'(unit_data_o), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"}, 32'(res_data), 32'd0);
        chk({tag, "_res_id"}, 32'(res_id), 32'd0);
        chk({tag, "_flush_done"}, 32'(flush_done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] stat_ops [5];
        n_tests = 0; n_fail = 0; ptr = 0; cyc = 0; draining = 0; saw_done = 0;
        rst_n = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b0; flush_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // single requester: positive then negative operand
        res_ready = 1'b1;
        req_valid = 4'b0001;
        req_data[15:0] = 16'h0005;
        cycle();
        req_data[15:0] = 16'h8003;
        cycle();
        req_valid = '0;
        repeat (4) cycle();

        // all requesters continuously valid
        req_valid = 4'hF;
        repeat (12) begin
            req_data = {$urandom, $urandom};
            cycle();
        end

        // backpressure: credits run out, then flow resumes
        res_ready = 1'b0;
        repeat (8) begin
            req_data = {$urandom, $urandom};
            cycle();
        end
        res_ready = 1'b1;
        repeat (8) cycle();
        req_valid = '0;
        repeat (4) cycle();

        // flush mid-stream with results outstanding
        req_valid = 4'hF;
        res_ready = 1'b0;
        repeat (3) begin
            req_data = {$urandom, $urandom};
            cycle();
        end
        flush_req = 1'b1;
        res_ready = 1'b1;
        drain_wait("flush_mid");

        // flush from idle with nothing outstanding
        req_valid = '0;
        flush_req = 1'b1;
        drain_wait("flush_idle");

        // async reset while the FIFO is full
        req_valid = 4'hF;
        res_ready = 1'b0;
        repeat (6) begin
            req_data = {$urandom, $urandom};
            cycle();
        end
        chk("fifo_full_busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        ptr = 0;
        draining = 1'b0;
        res_ready = 1'b1;
        repeat (6) cycle();

        // randomized traffic
        repeat (400) begin
            req_valid = N'($urandom);
            req_data  = {$urandom, $urandom};
            res_ready = ($urandom_range(3) != 0);
            cycle();
        end
        req_valid = '0;
        res_ready = 1'b1;
        flush_req = 1'b1;
        drain_wait("flush_final");

`ifdef ACT_STATS_EN
        stat_ops = '{16'h8001, 16'h0002, 16'hFFFF, 16'h7000, 16'h8000};
        chk("stat_issued_clr0", stat_issued, 32'd0);
        req_valid = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            req_data[31:16] = stat_ops[i];
            cycle();
        end
        req_valid = '0;
        repeat (4) cycle();
        chk("stat_issued", stat_issued, 32'd5);
        chk("stat_clamped", stat_clamped, 32'd3);
        flush_req = 1'b1;
        drain_wait("flush_stats");
        chk("stat_issued_clr", stat_issued, 32'd0);
        chk("stat_clamped_clr", stat_clamped, 32'd0);
`else
        stat_ops = '{default: '0};
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
